// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared encodings, defaults and the pattern step function for the LED controller
package led_ctrl_pkg;

  localparam int PERIOD_W = 25;
  localparam logic [PERIOD_W-1:0] TICK_MAX_DEFAULT = 25'd24_999_999;
  localparam logic [7:0] PP_SEED = 8'h01;

  typedef enum logic [2:0] {
    MODE_ROT_L    = 3'd0,
    MODE_ROT_R    = 3'd1,
    MODE_BLINK    = 3'd2,
    MODE_PINGPONG = 3'd3,
    MODE_STATIC   = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  // Encodings 5-7 are reserved and must be rejected.
  function automatic logic mode_reserved(input logic [2:0] m);
    return m > 3'd4;
  endfunction

  // Next LED value for one pattern step; PINGPONG shifts toward dir_left.
  function automatic logic [7:0] step_led(input mode_e m, input logic [7:0] l, input logic dir_left);
    return m == MODE_ROT_L    ? {l[6:0], l[7]} :
           m == MODE_ROT_R    ? {l[0], l[7:1]} :
           m == MODE_BLINK    ? ~l :
           m == MODE_PINGPONG ? (dir_left ? {l[6:0], 1'b0} : {1'b0, l[7:1]}) :
           l;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: programmable period counter producing a step strobe and a registered tick pulse
module led_tick_gen
  import led_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                hit,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;

  // Count while enabled, wrap to zero on reaching the period, clear on request.
  always_comb begin
    hit    = enable && (cnt_q == period);
    cnt_d  = clear ? '0 : hit ? '0 : enable ? cnt_q + 25'd1 : cnt_q;
    tick_d = hit;
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: configurable LED pattern sequencer with run/pause/apply control FSM
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] TICK_MAX = TICK_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_mode,
  input  logic [7:0]          cfg_pattern,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                run_en,
  output logic [7:0]          led,
  output logic                tick,
  output logic                cfg_err
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [7:0]          led_q, led_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                dir_q, dir_d;
  logic [2:0]          pmode_q, pmode_d;
  logic [7:0]          ppat_q, ppat_d;
  logic [PERIOD_W-1:0] pper_q, pper_d;
  logic                err_q, err_d;
  logic                xfer, apply_ok, hit;

  assign cfg_ready = state_q != ST_APPLY;

  led_tick_gen u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (apply_ok),
    .enable (state_q == ST_RUN),
    .period (period_q),
    .hit    (hit),
    .tick   (tick)
  );

  // Next state, config capture/apply and pattern stepping; a transfer pre-empts a coincident step.
  always_comb begin
    xfer     = cfg_valid && cfg_ready;
    apply_ok = (state_q == ST_APPLY) && !mode_reserved(pmode_q);
    state_d  = state_q == ST_APPLY ? (run_en ? ST_RUN : ST_PAUSE) :
               xfer ? ST_APPLY : run_en ? ST_RUN : ST_PAUSE;
    mode_d   = mode_q;
    led_d    = led_q;
    period_d = period_q;
    dir_d    = dir_q;
    pmode_d  = xfer ? cfg_mode : pmode_q;
    ppat_d   = xfer ? cfg_pattern : ppat_q;
    pper_d   = xfer ? cfg_period : pper_q;
    err_d    = xfer && mode_reserved(cfg_mode);
    if (apply_ok) begin
      mode_d   = mode_e'(pmode_q);
      led_d    = pmode_q == MODE_PINGPONG ? PP_SEED : ppat_q;
      period_d = pper_q;
      dir_d    = 1'b1;
    end else if (hit && !xfer) begin
      led_d = step_led(mode_q, led_q, dir_q);
      dir_d = mode_q != MODE_PINGPONG ? dir_q :
              led_d == 8'h80 ? 1'b0 : led_d == 8'h01 ? 1'b1 : dir_q;
    end
  end

  // State and configuration registers; reset drops any pending configuration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      mode_q   <= MODE_ROT_L;
      led_q    <= PP_SEED;
      period_q <= TICK_MAX;
      dir_q    <= 1'b1;
      pmode_q  <= '0;
      ppat_q   <= '0;
      pper_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      pmode_q  <= pmode_d;
      ppat_q   <= ppat_d;
      pper_q   <= pper_d;
      err_q    <= err_d;
    end
  end

  assign led     = led_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: scoreboard bench, stimulus pushes expected tick values, monitor pops and compares
module tb_led_pattern_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_mode = 3'd0;
  logic [7:0]  cfg_pattern = 8'h00;
  logic [24:0] cfg_period = 25'd0;
  logic        run_en = 1'b1;
  logic [7:0]  led;
  logic        tick;
  logic        cfg_err;

  typedef struct {
    logic [7:0] led;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   err_pushed = 0;
  int   err_seen = 0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.TICK_MAX(25'd3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_pattern (cfg_pattern),
    .cfg_period  (cfg_period),
    .run_en      (run_en),
    .led         (led),
    .tick        (tick),
    .cfg_err     (cfg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] l, input int g);
    exp_t e;
    e.led = l;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait until at most n expectations remain; stop=1 mutes the monitor afterwards.
  task automatic wait_q(input int n, input bit stop);
    int k = 0;
    while (exp_q.size() > n && k < 200) begin
      step(1);
      k++;
    end
    if (stop) mon_on = 1'b0;
    chk("queue_drain", 32'(exp_q.size()), 32'(n));
    if (exp_q.size() > n) exp_q.delete();
  endtask

  // Full configuration handshake; ticks during the handshake window are not scored.
  task automatic cfg(input logic [2:0] m, input logic [7:0] p, input logic [24:0] per, input bit bad);
    step(1);
    mon_on = 1'b0;
    cfg_valid = 1'b1;
    cfg_mode = m;
    cfg_pattern = p;
    cfg_period = per;
    if (bad) err_pushed++;
    step(1);
    cfg_valid = 1'b0;
    chk("ready_apply", 32'(cfg_ready), 32'd0);
    step(1);
    chk("ready_back", 32'(cfg_ready), 32'd1);
    if (!bad) chk("seed_load", 32'(led), 32'(m == 3'd3 ? 8'h01 : p));
    mon_on = 1'b1;
  endtask

  task automatic mon();
    int   cyc = 0;
    int   last = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn && mon_on && tick) begin
        if (exp_q.size() == 0) chk("tick_unexpected", 32'(tick), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("tick_led", 32'(led), 32'(e.led));
          if (e.gap != 0) chk("tick_gap", 32'(cyc - last), 32'(e.gap));
        end
      end
      if (tick) last = cyc;
      if (rstn && cfg_err) begin
        if (err_seen < err_pushed) begin
          err_seen++;
          chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        end else chk("cfg_err_unexpected", 32'(cfg_err), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] l;
    bit         d;
    fork
      mon();
    join_none
    #1 rstn = 1'b0;
    #2;
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    step(2);
    rstn = 1'b1;
    mon_on = 1'b1;
    l = 8'h01;
    for (int i = 0; i < 8; i++) begin
      l = {l[6:0], l[7]};
      push(l, i == 0 ? 0 : 4);
    end
    step(1);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);
    wait_q(0, 1'b1);
    chk("rot_l_wrap", 32'(led), 32'h01);

    cfg(3'd3, 8'h5A, 25'd0, 1'b0);
    l = 8'h01;
    d = 1'b1;
    for (int i = 0; i < 15; i++) begin
      l = d ? {l[6:0], 1'b0} : {1'b0, l[7:1]};
      if (l == 8'h80) d = 1'b0;
      if (l == 8'h01) d = 1'b1;
      push(l, i == 0 ? 0 : 1);
    end
    wait_q(0, 1'b1);

    cfg(3'd2, 8'h00, 25'd0, 1'b0);
    push(8'hFF, 0); push(8'h00, 1); push(8'hFF, 1);
    wait_q(0, 1'b1);
    cfg(3'd0, 8'h00, 25'd0, 1'b0);
    push(8'h00, 0); push(8'h00, 1);
    wait_q(0, 1'b1);
    cfg(3'd4, 8'hC3, 25'd0, 1'b0);
    push(8'hC3, 0); push(8'hC3, 1); push(8'hC3, 1);
    wait_q(0, 1'b1);

    cfg(3'd0, 8'h11, 25'd3, 1'b0);
    push(8'h22, 0); push(8'h44, 4); push(8'h88, 4); push(8'h11, 4);
    wait_q(0, 1'b0);
    cfg(3'd6, 8'hFF, 25'd0, 1'b1);
    push(8'h22, 0); push(8'h44, 4);
    wait_q(0, 1'b1);

    cfg(3'd2, 8'hA5, 25'd1, 1'b0);
    push(8'h5A, 0); push(8'hA5, 2); push(8'h5A, 2); push(8'hA5, 0); push(8'h5A, 2);
    wait_q(3, 1'b0);
    run_en = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("pause_led", 32'(led), 32'h5A);
      chk("pause_tick", 32'(tick), 32'd0);
    end
    run_en = 1'b1;
    wait_q(0, 1'b1);

    cfg(3'd0, 8'h01, 25'd3, 1'b0);
    push(8'h02, 0);
    wait_q(0, 1'b0);
    step(2);
    cfg_valid = 1'b1;
    cfg_mode = 3'd1;
    cfg_pattern = 8'h3C;
    cfg_period = 25'd3;
    push(8'h02, 4);
    step(1);
    cfg_valid = 1'b0;
    chk("collide_ready", 32'(cfg_ready), 32'd0);
    step(1);
    chk("collide_seed", 32'(led), 32'h3C);
    push(8'h1E, 0); push(8'h0F, 4);
    wait_q(0, 1'b1);

    step(1);
    cfg_valid = 1'b1;
    cfg_mode = 3'd2;
    cfg_pattern = 8'hF0;
    cfg_period = 25'd0;
    step(1);
    cfg_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("apply_rst_led", 32'(led), 32'h01);
    chk("apply_rst_tick", 32'(tick), 32'd0);
    chk("apply_rst_err", 32'(cfg_err), 32'd0);
    chk("apply_rst_ready", 32'(cfg_ready), 32'd1);
    step(2);
    rstn = 1'b1;
    mon_on = 1'b1;
    push(8'h02, 0); push(8'h04, 4); push(8'h08, 4);
    step(1);
    chk("apply_rst_hold", 32'(led), 32'h01);
    wait_q(0, 1'b1);

    step(2);
    chk("err_all_seen", 32'(err_seen), 32'(err_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
